// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, data widths and the idle fill byte.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;
  localparam int unsigned SPI_CNT_W  = 3;

  typedef logic [SPI_DATA_W-1:0] spi_byte_t;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  localparam spi_byte_t SPI_IDLE_FILL = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with optional rise/fall strobes
// derived from a history flop on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

  // History flop only where an edge is actually needed.
  generate
    if (EDGE_EN) begin : g_edge
      logic hist_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hist_q <= 1'b0;
        end else begin
          hist_q <= level;
        end
      end

      assign rise_c = level & ~hist_q;
      assign fall_c = ~level & hist_q;
    end else begin : g_no_edge
      assign rise_c = 1'b0;
      assign fall_c = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave_core.sv
// Mode-0 SPI slave: oversamples sclk/cs_n/mosi on clk, shifts bytes MSB first in both
// directions, with a single-byte transmit holding register and a received-byte strobe.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sclk),
    .level    (sclk_lvl_unused),
    .rise_c   (sclk_rise),
    .fall_c   (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_cs (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (cs_n),
    .level    (cs_lvl_unused),
    .rise_c   (cs_rise),
    .fall_c   (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (mosi),
    .level    (mosi_s),
    .rise_c   (mosi_rise_unused),
    .fall_c   (mosi_fall_unused)
  );

  spi_state_e           state_q, state_d;
  logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  spi_byte_t            rx_sr_q, rx_sr_d;
  spi_byte_t            tx_sr_q, tx_sr_d;
  spi_byte_t            hold_q, hold_d;
  spi_byte_t            rx_data_q, rx_data_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 underrun_q, underrun_d;
  logic                 miso_q, miso_d;
  logic                 miso_oe_q, miso_oe_d;
  logic                 busy_q, busy_d;

  logic active, tx_accept, sclk_rise_act, sclk_fall_act, byte_end, tx_load, abort;

  // A cs_n rise wins over any sclk edge seen in the same cycle.
  assign active        = (state_q == SPI_ACTIVE);
  assign tx_accept     = tx_valid & tx_ready_q;
  assign abort         = active & cs_rise;
  assign sclk_rise_act = active & sclk_rise & ~cs_rise;
  assign sclk_fall_act = active & sclk_fall & ~cs_rise;
  // Every fall follows a rise, so a fall with the counter at 0 closes a whole byte.
  assign byte_end      = sclk_fall_act & (bit_cnt_q == '0);
  assign tx_load       = (~active & cs_fall) | byte_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SPI_IDLE;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;

    case (state_q)
      SPI_IDLE:   if (cs_fall) state_d = SPI_ACTIVE;
      SPI_ACTIVE: if (cs_rise) state_d = SPI_IDLE;
      default:    state_d = SPI_IDLE;
    endcase

    // Holding register: a load takes the old contents; an accept only lands when empty.
    if (tx_accept) begin
      hold_d = tx_data;
    end

    if (tx_load) begin
      if (!tx_ready_q) begin
        tx_sr_d    = hold_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_sr_d    = SPI_IDLE_FILL;
        underrun_d = 1'b1;
      end
    end else if (sclk_fall_act) begin
      tx_sr_d = {tx_sr_q[SPI_DATA_W-2:0], 1'b0};
    end

    if (tx_accept) begin
      tx_ready_d = 1'b0;
    end

    if (sclk_rise_act) begin
      rx_sr_d   = {rx_sr_q[SPI_DATA_W-2:0], mosi_s};
      bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
      if (bit_cnt_q == LAST_BIT) begin
        rx_data_d  = rx_sr_d;
        rx_valid_d = 1'b1;
      end
    end

    // Deselect mid-byte drops the partial byte without touching the holding register.
    if (abort) begin
      bit_cnt_d = '0;
      rx_sr_d   = '0;
      tx_sr_d   = '0;
    end

    miso_d    = (state_d == SPI_ACTIVE) ? tx_sr_d[SPI_DATA_W-1] : 1'b0;
    miso_oe_d = (state_d == SPI_ACTIVE);
    busy_d    = (state_d == SPI_ACTIVE);
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign busy        = busy_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a behavioural SPI master plus a byte-queue model of the
// transmit path, checked against directed and randomized transfers.
module tb_spi_slave_core;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_slave_core #(.SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Model: bytes handed to the slave are consumed in order, one per byte start
  // (cs_n fall and the end of each full byte); none available means 8'h00 and an underrun.
  logic [7:0] feed_q  [$];
  logic [7:0] model_q [$];
  logic [7:0] rx_got  [$];
  logic [7:0] exp_rx  [$];
  logic [7:0] mo_buf  [4];
  int         und_cnt = 0;
  int         exp_und = 0;
  int         half    = 8;

  task automatic give(input logic [7:0] b);
    feed_q.push_back(b);
    model_q.push_back(b);
  endtask

  function automatic logic [7:0] model_load();
    if (model_q.size() > 0) return model_q.pop_front();
    exp_und++;
    return 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Feeder keeps the holding register topped up whenever the slave reports room.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_ready && feed_q.size() > 0) begin
        tx_data  = feed_q.pop_front();
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rx_valid) rx_got.push_back(rx_data);
    if (tx_underrun) und_cnt++;
  end

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_miso"},     32'(miso),        32'd0);
    chk({pfx, "_miso_oe"},  32'(miso_oe),     32'd0);
    chk({pfx, "_tx_ready"}, 32'(tx_ready),    32'd1);
    chk({pfx, "_rx_data"},  32'(rx_data),     32'd0);
    chk({pfx, "_rx_valid"}, 32'(rx_valid),    32'd0);
    chk({pfx, "_underrun"}, 32'(tx_underrun), 32'd0);
    chk({pfx, "_busy"},     32'(busy),        32'd0);
  endtask

  // One chip-select window clocking nbits bits of mo_buf; optionally reset mid-way.
  task automatic spi_xfer(input int nbits, input bit do_reset);
    logic [7:0] mi [4];
    logic [7:0] em [5];
    int nb;
    nb = nbits / 8;
    wait_clk(half);
    cs_n = 1'b0;
    em[0] = model_load();
    wait_clk(half);
    chk("busy_active", 32'(busy), 32'd1);
    chk("oe_active", 32'(miso_oe), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      mosi = mo_buf[b / 8][7 - (b % 8)];
      wait_clk(half);
      sclk = 1'b1;
      mi[b / 8][7 - (b % 8)] = miso;
      wait_clk(half);
      sclk = 1'b0;
      if (b % 8 == 7) begin
        em[b / 8 + 1] = model_load();
        exp_rx.push_back(mo_buf[b / 8]);
      end
    end
    if (do_reset) begin
      wait_clk(1);
      feed_q.delete();
      model_q.delete();
      rst_n = 1'b0;
      wait_clk(2);
      check_reset_vals("midrst");
      rst_n = 1'b1;
      cs_n  = 1'b1;
    end else begin
      wait_clk(half);
      cs_n = 1'b1;
    end
    wait_clk(half + 4);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("oe_idle", 32'(miso_oe), 32'd0);
    chk("miso_idle", 32'(miso), 32'd0);
    for (int k = 0; k < nb; k++) chk("miso_byte", 32'(mi[k]), 32'(em[k]));
    chk("rx_count", 32'(rx_got.size()), 32'(exp_rx.size()));
    while (exp_rx.size() > 0 && rx_got.size() > 0)
      chk("rx_byte", 32'(rx_got.pop_front()), 32'(exp_rx.pop_front()));
    exp_rx.delete();
    rx_got.delete();
    chk("underruns", 32'(und_cnt), 32'(exp_und));
    chk("tx_ready", 32'(tx_ready), 32'(model_q.size() == 0));
  endtask

  initial begin
    wait_clk(3);
    check_reset_vals("init");
    rst_n = 1'b1;
    wait_clk(4);

    // Preloaded A5 while the master sends 3C.
    give(8'hA5);
    mo_buf[0] = 8'h3C;
    spi_xfer(8, 1'b0);

    // Three back-to-back bytes; a fourth refill covers the closing byte boundary.
    give(8'h01); give(8'h02); give(8'h03); give(8'h04);
    for (int i = 0; i < 3; i++) mo_buf[i] = 8'($urandom);
    spi_xfer(24, 1'b0);

    // Empty holding register at cs_n fall.
    mo_buf[0] = 8'($urandom);
    spi_xfer(8, 1'b0);

    // Deselect after 5 bits, then a clean F0 transfer using the byte left in holding.
    give(8'h5A); give(8'hC3);
    mo_buf[0] = 8'($urandom);
    spi_xfer(5, 1'b0);
    mo_buf[0] = 8'hF0;
    spi_xfer(8, 1'b0);

    // Reset after bit 3, then a normal transfer.
    give(8'($urandom));
    mo_buf[0] = 8'($urandom);
    spi_xfer(3, 1'b1);
    give(8'h96);
    mo_buf[0] = 8'($urandom);
    spi_xfer(8, 1'b0);

    // Randomized transfers with varying sclk rate, length and tx supply.
    for (int it = 0; it < 8; it++) begin
      int nb;
      int ng;
      half = int'($urandom_range(SYNC + 3, SYNC + 7));
      nb   = int'($urandom_range(1, 3));
      ng   = int'($urandom_range(0, nb + 1));
      for (int g = 0; g < ng; g++) give(8'($urandom));
      for (int i = 0; i < nb; i++) mo_buf[i] = 8'($urandom);
      spi_xfer(nb * 8, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the input synchronizers (legal 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port sclk  input  1  SPI serial clock from the master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-005 SHALL have port cs_n  input  1  chip select from the master, active-low, asynchronous.
REQ-006 SHALL have port mosi  input  1  serial data from the master, asynchronous.
REQ-007 SHALL have port miso  output  1  serial data to the master, MSB first.
REQ-008 SHALL have port miso_oe  output  1  high while selected; the pad drives miso only when miso_oe is high.
REQ-009 SHALL have port tx_data  input  8  next byte to transmit.
REQ-010 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-011 SHALL have port tx_ready  output  1  transmit holding register is empty.
REQ-012 SHALL have port rx_data  output  8  last complete received byte.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data is updated.
REQ-014 SHALL have port tx_underrun  output  1  one-cycle pulse: a byte was started with the holding register empty.
REQ-015 SHALL have port busy  output  1  high in the ACTIVE state.

Function
REQ-016 SHALL pass sclk, cs_n and mosi through SYNC_STAGES-deep synchronizers, plus one history flop on sclk and cs_n for edge detection.
REQ-017 SHALL detect sclk rise/fall and cs_n fall/rise as single-cycle strobes from the synchronized signals.
REQ-018 SHALL implement the states IDLE and ACTIVE; IDLE->ACTIVE on cs_n fall, ACTIVE->IDLE on cs_n rise.
REQ-019 SHALL accept a transmit byte into the holding register on any cycle with tx_valid and tx_ready both high; tx_ready is low while the register is full.
REQ-020 SHALL, on cs_n fall and on the sclk fall that ends every 8th bit, load the shift register from the holding register (emptying it) if full, else load 8'h00 and pulse tx_underrun.
REQ-021 SHALL, when the holding register is accepted in the same cycle as a load, use the old contents for the load and keep the new byte in the holding register.
REQ-022 SHALL sample synchronized mosi into the receive shift register on every sclk rise in ACTIVE, MSB first, and increment a 3-bit bit counter (wraps 7->0).
REQ-023 SHALL, on the sclk rise that completes bit 7, write the assembled byte to rx_data and pulse rx_valid in the next cycle; no backpressure, rx_data holds until overwritten.
REQ-024 SHALL shift the transmit shift register left on every sclk fall in ACTIVE except the byte-boundary fall of REQ-020; miso equals its MSB.
REQ-025 SHALL drive miso_oe high and busy high in ACTIVE, both low in IDLE; miso is 0 in IDLE.
REQ-026 SHALL, on cs_n rise mid-byte, discard the partial byte, clear the bit counter, assert no rx_valid, and leave the holding register unchanged.
REQ-027 SHALL ignore sclk edges in IDLE.
REQ-028 SHALL be correct only when sclk high and low phases each last at least SYNC_STAGES+3 clk cycles and cs_n fall precedes the first sclk rise by the same amount.

Reset
REQ-029 SHALL, while rst_n is low at a clk edge, enter IDLE and clear synchronizers, shift registers, bit counter, holding register and rx_data to 0.
REQ-030 SHALL hold outputs in reset at: miso 0, miso_oe 0, tx_ready 1, rx_data 8'h00, rx_valid 0, tx_underrun 0, busy 0.
REQ-031 SHALL, on reset asserted mid-transfer, abort without an rx_valid pulse, remaining in IDLE until the next cs_n fall after release.

Structure
REQ-032 SHALL take the state enum (IDLE, ACTIVE) and the idle fill byte 8'h00 from the shared SPI package used by the master.
REQ-033 SHALL instantiate one sub-module, spi_sync_edge, per asynchronous input, providing the synchronized level and rise/fall strobes.

Verification
REQ-034 SHALL cover: tx 8'hA5 preloaded, master sends 8'h3C -> miso carries 1010_0101, rx_data=8'h3C with one rx_valid pulse.
REQ-035 SHALL cover: three back-to-back bytes 8'h01,8'h02,8'h03 with tx refilled on tx_ready -> three rx_valid pulses, miso bytes in order, no tx_underrun.
REQ-036 SHALL cover: holding register empty at cs_n fall -> tx_underrun pulse, miso sends 8'h00.
REQ-037 SHALL cover: cs_n raised after 5 bits -> no rx_valid, next full transfer of 8'hF0 received correctly.
REQ-038 SHALL cover: rst_n low for 2 cycles after bit 3 -> all outputs at reset values, tx_ready=1, next transfer correct.
